// File: rtl/pulse_wave_seq.sv
// pulse_wave_seq: trapezoidal pulse/rect waveform sequencer driving the
// DAC-fed pulse and rect source stage. Produces one registered level code per
// clock. A run walks DELAY, RISE, HIGH, FALL and LOW, with linear ramps, as a
// single shot or periodically repeating RISE..LOW.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous reset, active low
//   en         enable; low aborts any run
//   start      single-cycle run request, only honoured in IDLE with en high
//   periodic   1 = repeat RISE..LOW forever, 0 = one shot
//   iv, pv     initial/low and pulse/high level codes (W bits, unsigned)
//   td..tl     delay, rise, high, fall and low lengths in cycles (CW bits)
//   level      current output level code
//   busy       high while not IDLE
//   phase      IDLE=0 DELAY=1 RISE=2 HIGH=3 FALL=4 LOW=5
//   done       one-cycle pulse when a one-shot run completes
module pulse_wave_seq #(
  parameter int W  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          periodic,
  input  logic [W-1:0]  iv,
  input  logic [W-1:0]  pv,
  input  logic [CW-1:0] td,
  input  logic [CW-1:0] tr,
  input  logic [CW-1:0] th,
  input  logic [CW-1:0] tf,
  input  logic [CW-1:0] tl,
  output logic [W-1:0]  level,
  output logic          busy,
  output logic [2:0]    phase,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_RISE  = 3'd2,
    S_HIGH  = 3'd3,
    S_FALL  = 3'd4,
    S_LOW   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  level_q, level_d;
  logic          done_q, done_d;
  logic          latch;

  logic [W-1:0]  iv_q, pv_q;
  logic [CW-1:0] td_q, tr_q, th_q, tf_q, tl_q;
  logic          per_q;

  logic          running;
  logic [W-1:0]  cIv, cPv;
  logic [CW-1:0] cTr, cTf, lenCur;
  logic [4:0]    nzIn, nzQ;
  logic [2:0]    nextIdx;

  // Returns the first phase at or after index 'from' whose length is non-zero.
  // Running off the end of LOW wraps to RISE..LOW when periodic; if nothing
  // non-zero remains the run ends in IDLE, so an all-zero periodic config
  // cannot loop on zero-length phases.
  function automatic state_t pickPhase(input logic [2:0] from,
                                       input logic [4:0] nz,
                                       input logic per);
    state_t res;
    logic   found;
    res   = S_IDLE;
    found = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (!found && (i >= int'(from)) && nz[i-1]) begin
        res   = state_t'(i[2:0]);
        found = 1'b1;
      end
    end
    if (!found && per) begin
      for (int i = 2; i <= 5; i++) begin
        if (!found && nz[i-1]) begin
          res   = state_t'(i[2:0]);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // k-th ramp point from base toward tgt over len cycles, truncated toward
  // zero. Working on the magnitude makes unsigned division truncate toward
  // zero for both ramp directions. The product is W+CW bits wide so it cannot
  // overflow, and the quotient never exceeds the magnitude since k <= len.
  function automatic logic [W-1:0] ramp(input logic [W-1:0]  base,
                                        input logic [W-1:0]  tgt,
                                        input logic [CW-1:0] k,
                                        input logic [CW-1:0] len);
    logic signed [W:0]  diff;
    logic [W-1:0]       mag;
    logic [W+CW-1:0]    prod;
    logic [W+CW-1:0]    den;
    logic [W-1:0]       quo;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, base});
    mag  = diff[W] ? W'(-diff) : W'(diff);
    prod = {{CW{1'b0}}, mag} * {{W{1'b0}}, k};
    den  = (len == '0) ? {{(W+CW-1){1'b0}}, 1'b1} : {{W{1'b0}}, len};
    quo  = W'(prod / den);
    return diff[W] ? (base - quo) : (base + quo);
  endfunction

  // While IDLE the live inputs feed the first-cycle computation, since the
  // config is only latched on the same edge that leaves IDLE.
  always_comb begin
    running = (state_q != S_IDLE);
    cIv     = running ? iv_q : iv;
    cPv     = running ? pv_q : pv;
    cTr     = running ? tr_q : tr;
    cTf     = running ? tf_q : tf;
    nzIn    = {tl != '0, tf != '0, th != '0, tr != '0, td != '0};
    nzQ     = {tl_q != '0, tf_q != '0, th_q != '0, tr_q != '0, td_q != '0};
    nextIdx = 3'(state_q) + 3'd1;
    case (state_q)
      S_DELAY: lenCur = td_q;
      S_RISE:  lenCur = tr_q;
      S_HIGH:  lenCur = th_q;
      S_FALL:  lenCur = tf_q;
      S_LOW:   lenCur = tl_q;
      default: lenCur = '0;
    endcase
  end

  // Next-state, next-count and next-level decode; k counts cycles already
  // spent in the phase, starting at 1 on phase entry.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    level_d = level_q;

    if (!running) begin
      if (en && start) begin
        latch   = 1'b1;
        state_d = pickPhase(3'd1, nzIn, periodic);
        k_d     = (state_d == S_IDLE) ? '0 : {{(CW-1){1'b0}}, 1'b1};
        done_d  = (state_d == S_IDLE);
      end
    end else if (!en) begin
      state_d = S_IDLE;
      k_d     = '0;
    end else if (k_q >= lenCur) begin
      state_d = pickPhase(nextIdx, nzQ, per_q);
      k_d     = (state_d == S_IDLE) ? '0 : {{(CW-1){1'b0}}, 1'b1};
      done_d  = (state_d == S_IDLE);
    end else begin
      k_d = k_q + 1'b1;
    end

    case (state_d)
      S_DELAY, S_LOW: level_d = cIv;
      S_HIGH:         level_d = cPv;
      S_RISE:         level_d = ramp(cIv, cPv, k_d, cTr);
      S_FALL:         level_d = ramp(cPv, cIv, k_d, cTf);
      default: begin
        if (running && !en)
          level_d = iv_q;
        else if (latch)
          level_d = iv;
        else
          level_d = level_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      level_q <= '0;
      done_q  <= 1'b0;
      iv_q    <= '0;
      pv_q    <= '0;
      td_q    <= '0;
      tr_q    <= '0;
      th_q    <= '0;
      tf_q    <= '0;
      tl_q    <= '0;
      per_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      level_q <= level_d;
      done_q  <= done_d;
      if (latch) begin
        iv_q  <= iv;
        pv_q  <= pv;
        td_q  <= td;
        tr_q  <= tr;
        th_q  <= th;
        tf_q  <= tf;
        tl_q  <= tl;
        per_q <= periodic;
      end
    end
  end

  assign level = level_q;
  assign phase = 3'(state_q);
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_pulse_wave_seq.sv
// tb_pulse_wave_seq: self-checking bench for pulse_wave_seq. Directed vectors
// from the test plan, hand-written abort/reset sequences, and randomized runs
// compared with a phase-by-phase waveform model.
module tb_pulse_wave_seq;

  localparam int W  = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          start;
  logic          periodic;
  logic [W-1:0]  iv, pv;
  logic [CW-1:0] td, tr, th, tf, tl;
  logic [W-1:0]  level;
  logic          busy;
  logic [2:0]    phase;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int iv, pv, td, tr, th, tf, tl;
    bit per;
    int n;
    int doneAt;
  } vec_t;

  vec_t tbl[5];
  int   expTbl[5][16];
  int   expLv[$];
  int   expPh[$];

  pulse_wave_seq #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .periodic(periodic),
    .iv(iv), .pv(pv), .td(td), .tr(tr), .th(th), .tf(tf), .tl(tl),
    .level(level), .busy(busy), .phase(phase), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setConfig(input vec_t v);
    iv       = W'(v.iv);
    pv       = W'(v.pv);
    td       = CW'(v.td);
    tr       = CW'(v.tr);
    th       = CW'(v.th);
    tf       = CW'(v.tf);
    tl       = CW'(v.tl);
    periodic = v.per;
  endtask

  // Drives the config plus a one-cycle start; returns at the sample point of
  // cycle 1 after the accepting edge.
  task automatic applyStimulus(input vec_t v);
    setConfig(v);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waveform model: lay out each phase's cycles in order from the rule
  // level = base + (target-base)*k/len, using signed int division.
  task automatic buildModel(input vec_t v, input int maxC, output bit endsDone);
    bit allZ;
    expLv.delete();
    expPh.delete();
    allZ = (v.tr + v.th + v.tf + v.tl) == 0;
    repeat (v.td) begin expPh.push_back(1); expLv.push_back(v.iv); end
    do begin
      for (int k = 1; k <= v.tr; k++) begin
        expPh.push_back(2); expLv.push_back(v.iv + ((v.pv - v.iv) * k) / v.tr);
      end
      repeat (v.th) begin expPh.push_back(3); expLv.push_back(v.pv); end
      for (int k = 1; k <= v.tf; k++) begin
        expPh.push_back(4); expLv.push_back(v.pv + ((v.iv - v.pv) * k) / v.tf);
      end
      repeat (v.tl) begin expPh.push_back(5); expLv.push_back(v.iv); end
    end while (v.per && !allZ && expLv.size() < maxC);
    endsDone = !v.per || allZ;
  endtask

  task automatic runVec(input int idx);
    vec_t v;
    int   held;
    v = tbl[idx];
    applyStimulus(v);
    for (int c = 1; c <= v.n; c++) begin
      checkOutput($sformatf("vec%0d level c%0d", idx, c), int'(level), expTbl[idx][c-1]);
      checkOutput($sformatf("vec%0d busy c%0d", idx, c), int'(busy), 1);
      checkOutput($sformatf("vec%0d done c%0d", idx, c), int'(done), 0);
      step();
    end
    held = (v.n > 0) ? expTbl[idx][v.n-1] : v.iv;
    if (v.doneAt != 0) begin
      checkOutput($sformatf("vec%0d done pulse", idx), int'(done), 1);
      checkOutput($sformatf("vec%0d busy end", idx), int'(busy), 0);
      checkOutput($sformatf("vec%0d phase end", idx), int'(phase), 0);
      checkOutput($sformatf("vec%0d level end", idx), int'(level), held);
      step();
      checkOutput($sformatf("vec%0d done clear", idx), int'(done), 0);
      checkOutput($sformatf("vec%0d level hold", idx), int'(level), held);
    end else begin
      en = 1'b0;
      step();
      checkOutput($sformatf("vec%0d stop phase", idx), int'(phase), 0);
      checkOutput($sformatf("vec%0d stop level", idx), int'(level), v.iv);
      checkOutput($sformatf("vec%0d stop done", idx), int'(done), 0);
      en = 1'b1;
    end
  endtask

  task automatic runRandom(input int r);
    vec_t v;
    bit   endsDone;
    int   held;
    v.iv  = int'($urandom_range(0, 4095));
    v.pv  = int'($urandom_range(0, 4095));
    v.td  = int'($urandom_range(0, 3));
    v.tr  = int'($urandom_range(0, 5));
    v.th  = int'($urandom_range(0, 3));
    v.tf  = int'($urandom_range(0, 5));
    v.tl  = int'($urandom_range(0, 3));
    v.per = 1'($urandom_range(0, 1));
    v.n   = 0;
    v.doneAt = 0;
    buildModel(v, 40, endsDone);
    applyStimulus(v);
    for (int c = 0; c < expLv.size(); c++) begin
      checkOutput($sformatf("rnd%0d level c%0d", r, c+1), int'(level), expLv[c]);
      checkOutput($sformatf("rnd%0d phase c%0d", r, c+1), int'(phase), expPh[c]);
      checkOutput($sformatf("rnd%0d done c%0d", r, c+1), int'(done), 0);
      step();
    end
    if (endsDone) begin
      held = (expLv.size() > 0) ? expLv[$] : v.iv;
      checkOutput($sformatf("rnd%0d done pulse", r), int'(done), 1);
      checkOutput($sformatf("rnd%0d busy end", r), int'(busy), 0);
      checkOutput($sformatf("rnd%0d level end", r), int'(level), held);
    end else begin
      en = 1'b0;
      step();
      checkOutput($sformatf("rnd%0d abort phase", r), int'(phase), 0);
      checkOutput($sformatf("rnd%0d abort level", r), int'(level), v.iv);
      checkOutput($sformatf("rnd%0d abort done", r), int'(done), 0);
      en = 1'b1;
    end
    step();
  endtask

  initial begin
    tbl[0] = '{iv:0,  pv:100, td:2, tr:4, th:3, tf:2, tl:1, per:1'b0, n:12, doneAt:13};
    tbl[1] = '{iv:10, pv:0,   td:0, tr:3, th:1, tf:0, tl:0, per:1'b0, n:4,  doneAt:5};
    tbl[2] = '{iv:0,  pv:8,   td:3, tr:2, th:1, tf:2, tl:1, per:1'b1, n:15, doneAt:0};
    tbl[3] = '{iv:5,  pv:50,  td:0, tr:0, th:2, tf:0, tl:0, per:1'b0, n:2,  doneAt:3};
    tbl[4] = '{iv:77, pv:9,   td:0, tr:0, th:0, tf:0, tl:0, per:1'b1, n:0,  doneAt:1};
    expTbl[0] = '{0,0,25,50,75,100,100,100,100,50,0,0,0,0,0,0};
    expTbl[1] = '{7,4,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    expTbl[2] = '{0,0,0,4,8,8,4,0,0,4,8,8,4,0,0,0};
    expTbl[3] = '{50,50,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    expTbl[4] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

    rst_n = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    setConfig(tbl[0]);
    #12;
    checkOutput("reset level", int'(level), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset phase", int'(phase), 0);
    checkOutput("reset done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) runVec(i);

    // Start while disabled in IDLE must be ignored.
    en = 1'b0;
    applyStimulus(tbl[0]);
    checkOutput("en0 start busy", int'(busy), 0);
    checkOutput("en0 start phase", int'(phase), 0);
    en = 1'b1;
    step();

    // Abort during HIGH of the basic case.
    applyStimulus(tbl[0]);
    repeat (6) step();
    checkOutput("abort pre phase", int'(phase), 3);
    en = 1'b0;
    step();
    checkOutput("abort phase", int'(phase), 0);
    checkOutput("abort level", int'(level), 0);
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    step();
    checkOutput("abort done later", int'(done), 0);
    en = 1'b1;

    // A second start with a different config mid-run changes nothing.
    applyStimulus(tbl[0]);
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("midstart level c%0d", c), int'(level), expTbl[0][c-1]);
      if (c == 3) begin
        iv = 12'd500; pv = 12'd900; tr = 16'd7; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    checkOutput("midstart done", int'(done), 1);
    step();

    // Asynchronous reset mid-RISE clears outputs before the next edge.
    applyStimulus(tbl[0]);
    repeat (3) step();
    checkOutput("prereset level", int'(level), 50);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async level", int'(level), 0);
    checkOutput("async phase", int'(phase), 0);
    checkOutput("async busy", int'(busy), 0);
    checkOutput("async done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    runVec(0);

    for (int r = 0; r < 30; r++) runRandom(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_wave_seq.md
Name: pulse_wave_seq

Overview:
- Digital trapezoidal pulse/rect waveform sequencer that feeds the DAC-driven pulse and rect source stage.
- Produces one registered level code per clock. The waveform has the phases delay, rise, high, fall and low, with linear ramps, as a single shot or periodic.
- The config mirrors the source parameter set (iv/pv, Td, Tr, TH, Tf, TL) in clock-cycle units.

Parameters:
- W, 12, width of level codes iv, pv and level (unsigned).
- CW, 16, width of each phase-length count.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- en  in  1  enable; low aborts any run.
- start  in  1  single-cycle request to begin a run; sampled only in IDLE.
- periodic  in  1  1 = repeat rise..low forever; 0 = one shot.
- iv  in  W  initial/low level code.
- pv  in  W  pulse/high level code.
- td, tr, th, tf, tl  in  CW each  phase lengths in cycles for delay, rise, high, fall and low.
- level  out  W  current output level code.
- busy  out  1  high while not IDLE.
- phase  out  3  state code: IDLE=0, DELAY=1, RISE=2, HIGH=3, FALL=4, LOW=5.
- done  out  1  one-cycle pulse when a one-shot run completes.

Behaviour:
- Reset (async, rst_n=0): state IDLE, level=0, busy=0, phase=0, done=0, all counters and latched config cleared.
- Config (iv, pv, td..tl, periodic) is latched on the accepted start. Input changes during a run are ignored.
- Accept rule: start is accepted only when in IDLE and en=1. A start during a run is ignored.
- Latency: start accepted in cycle N means cycle N+1 shows the first cycle of the first non-zero phase, beginning at DELAY.
- Level is registered and phase is updated in the same edge.
- Phase lengths: each phase lasts exactly its count in cycles. A phase with count 0 is skipped with no extra cycle.
- DELAY: occurs once per run, never on periodic repeats. level=iv.
- RISE, k-th cycle (k=1..tr): level = iv + trunc((pv-iv)*k/tr).
  - The difference is signed, W+1 bits; trunc is toward zero.
  - The last rise cycle is exactly pv.
  - pv<iv (inverted pulse) is legal.
- HIGH: level=pv.
- FALL, k-th cycle (k=1..tf): level = pv + trunc((iv-pv)*k/tf). The last cycle is exactly iv.
- LOW: level=iv.
- Ramp implementation is free (Bresenham accumulator, precomputed step plus remainder, etc.). Output must match the formula bit-exactly each cycle with no added latency.
- Ramp internal products must not overflow for any legal W/CW; size the intermediates accordingly.
- End of LOW (or of the last non-zero phase):
  - periodic=1: next cycle is the first non-zero phase of RISE/HIGH/FALL/LOW.
  - periodic=0: next cycle is IDLE with done=1 for that one cycle, busy=0, and level holding its last value.
- All of tr, th, tf, tl zero:
  - one shot: IDLE right after DELAY (or immediately if td=0), with done pulse and level=iv.
  - periodic: same as one shot. No infinite zero-length loop; done still pulses.
- en=0 during a run: next cycle goes to IDLE, level=latched iv, done stays 0, busy=0.
- en=0 in IDLE: start is ignored.
- Reset mid-run: immediate async return to reset values. No done pulse.
- IDLE hold: level holds its value until the next accepted start.

Test Plan:
- Basic one shot: iv=0, pv=100, td=2, tr=4, th=3, tf=2, tl=1, periodic=0; start at cycle 0 -> levels in cycles 1..12 are 0,0,25,50,75,100,100,100,100,50,0,0; cycle 13 shows done=1, busy=0, phase=0.
- Inverted truncating ramp: iv=10, pv=0, td=0, tr=3, th=1, tf=0, tl=0 -> levels 7,4,0,0, then done.
- Periodic with delay once: iv=0, pv=8, td=3, tr=2, th=1, tf=2, tl=1, periodic=1 -> 0,0,0,4,8,8,4,0,0,4,8,8,4,0,0,...; DELAY appears only once; done never asserts.
- Zero phases: td=0, tr=0, th=2, tf=0, tl=0, pv=50, iv=5 -> 50,50, then done with level held 50.
- All-zero periodic -> start gives done on cycle 1 with level=iv, and no hang.
- Abort and restart: en dropped during HIGH of the basic case -> next cycle IDLE, level=0, no done. A start mid-run is ignored. Asserting rst_n=0 asynchronously mid-RISE clears outputs before the next clk edge. After release, a fresh start replays the basic-case sequence exactly.
